// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control unit and the ALU control decoder.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned STATE_W  = 4;

  // Instruction opcodes, bits [31:26]
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // Controller state encodings; 14 and 15 are unused
  localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] ST_FETCH    = 4'd1;
  localparam logic [STATE_W-1:0] ST_DECODE   = 4'd2;
  localparam logic [STATE_W-1:0] ST_MEM_ADDR = 4'd3;
  localparam logic [STATE_W-1:0] ST_MEM_RD   = 4'd4;
  localparam logic [STATE_W-1:0] ST_MEM_WB   = 4'd5;
  localparam logic [STATE_W-1:0] ST_MEM_WR   = 4'd6;
  localparam logic [STATE_W-1:0] ST_R_EXEC   = 4'd7;
  localparam logic [STATE_W-1:0] ST_R_WB     = 4'd8;
  localparam logic [STATE_W-1:0] ST_I_EXEC   = 4'd9;
  localparam logic [STATE_W-1:0] ST_I_WB     = 4'd10;
  localparam logic [STATE_W-1:0] ST_BRANCH   = 4'd11;
  localparam logic [STATE_W-1:0] ST_JUMP     = 4'd12;
  localparam logic [STATE_W-1:0] ST_TRAP     = 4'd13;

  // ALU operation class
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ASB_REG_B    = 2'b00;
  localparam logic [1:0] ASB_CONST4   = 2'b01;
  localparam logic [1:0] ASB_SEXT_IMM = 2'b10;
  localparam logic [1:0] ASB_SEXT_SH2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCS_ALU_RES = 2'b00;
  localparam logic [1:0] PCS_ALU_OUT = 2'b01;
  localparam logic [1:0] PCS_JUMP    = 2'b10;

  // Datapath strobe bundle produced per state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_instr;
  } ctrl_strobes_t;

  // True for opcodes that take the load/store address path
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/flag inputs, strobes and debug outputs.
interface multicycle_control_if #(
  parameter int unsigned COUNT_W = 32
);
  import mips_ctrl_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                illegal_instr;
  logic [COUNT_W-1:0]  instr_count;
  logic [STATE_W-1:0]  state;

  // Controller side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_instr, instr_count, state
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_instr, instr_count, state
  );

endinterface

// File: rtl/ctrl_out_decode.sv
// Pure state -> datapath strobe map; FETCH write strobes are qualified by the top.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output ctrl_strobes_t      strobes
);

  // Per-state strobe decode, everything low unless named
  always_comb begin
    strobes = '0;
    case (state)
      ST_FETCH: begin
        strobes.mem_read  = 1'b1;
        strobes.ir_write  = 1'b1;
        strobes.pc_write  = 1'b1;
        strobes.alu_src_b = ASB_CONST4;
        strobes.alu_op    = ALU_OP_ADD;
      end
      ST_DECODE: begin
        strobes.alu_src_b = ASB_SEXT_SH2;
      end
      ST_MEM_ADDR: begin
        strobes.alu_src_a = 1'b1;
        strobes.alu_src_b = ASB_SEXT_IMM;
      end
      ST_MEM_RD: begin
        strobes.mem_read = 1'b1;
        strobes.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        strobes.reg_write  = 1'b1;
        strobes.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        strobes.mem_write = 1'b1;
        strobes.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        strobes.alu_src_a = 1'b1;
        strobes.alu_src_b = ASB_REG_B;
        strobes.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        strobes.reg_write = 1'b1;
        strobes.reg_dst   = 1'b1;
      end
      ST_I_EXEC: begin
        strobes.alu_src_a = 1'b1;
        strobes.alu_src_b = ASB_SEXT_IMM;
        strobes.alu_op    = ALU_OP_ADD;
      end
      ST_I_WB: begin
        strobes.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        strobes.alu_src_a     = 1'b1;
        strobes.alu_op        = ALU_OP_SUB;
        strobes.pc_write_cond = 1'b1;
        strobes.pc_source     = PCS_ALU_OUT;
      end
      ST_JUMP: begin
        strobes.pc_write  = 1'b1;
        strobes.pc_source = PCS_JUMP;
      end
      ST_TRAP: begin
        strobes.illegal_instr = 1'b1;
      end
      default: strobes = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, sequencing, memory handshake and retire counter.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned COUNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               mem_done_c;
  logic               fetch_go_c;
  ctrl_strobes_t      strobes_c;

  // Memory access completes on mem_ready, or every cycle without the handshake
  always_comb begin
    mem_done_c = 1'b1;
    if (MEM_HANDSHAKE) begin
      mem_done_c = bus.mem_ready;
    end
    fetch_go_c = (state_q != ST_FETCH) || mem_done_c;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (mem_done_c) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_mem_op(bus.opcode))                             state_d = ST_MEM_ADDR;
        else if (bus.opcode == OP_RTYPE)                       state_d = ST_R_EXEC;
        else if (bus.opcode == OP_ADDI || bus.opcode == OP_ADDIU) state_d = ST_I_EXEC;
        else if (bus.opcode == OP_BEQ)                         state_d = ST_BRANCH;
        else if (bus.opcode == OP_J)                           state_d = ST_JUMP;
        else                                                   state_d = ST_TRAP;
      end
      ST_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_done_c) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_done_c) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Retire counter: one tick per re-entry into FETCH (the post-reset entry is not a retire)
  always_comb begin
    count_d = count_q;
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_IDLE)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  ctrl_out_decode u_decode (
    .state   (state_q),
    .strobes (strobes_c)
  );

  // Drive the bus; FETCH IR/PC writes only fire in the completing cycle
  assign bus.pc_write      = strobes_c.pc_write & fetch_go_c;
  assign bus.ir_write      = strobes_c.ir_write & fetch_go_c;
  assign bus.pc_write_cond = strobes_c.pc_write_cond;
  assign bus.i_or_d        = strobes_c.i_or_d;
  assign bus.mem_read      = strobes_c.mem_read;
  assign bus.mem_write     = strobes_c.mem_write;
  assign bus.mem_to_reg    = strobes_c.mem_to_reg;
  assign bus.reg_dst       = strobes_c.reg_dst;
  assign bus.reg_write     = strobes_c.reg_write;
  assign bus.alu_src_a     = strobes_c.alu_src_a;
  assign bus.alu_src_b     = strobes_c.alu_src_b;
  assign bus.alu_op        = strobes_c.alu_op;
  assign bus.pc_source     = strobes_c.pc_source;
  assign bus.illegal_instr = strobes_c.illegal_instr;
  assign bus.instr_count   = count_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: handshake instance plus a no-handshake, 3-bit-counter instance.
module tb_multicycle_control;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] sb;
    logic [31:0] cnt;
  } exp_t;

  // Hand-written state codes
  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1, S_DEC = 4'd2,  S_MADDR = 4'd3,
                         S_MRD  = 4'd4,  S_MWB   = 4'd5, S_MWR = 4'd6,  S_REX   = 4'd7,
                         S_RWB  = 4'd8,  S_IEX   = 4'd9, S_IWB = 4'd10, S_BR    = 4'd11,
                         S_JMP  = 4'd12, S_TRAP  = 4'd13;

  // Strobe vector: {pw,pwc,iord,mr,mw,irw,m2r,rdst,rw,asa}, alu_src_b, alu_op, pc_source, illegal
  localparam logic [16:0] SB_IDLE   = '0;
  localparam logic [16:0] SB_FGO    = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_FSTALL = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_DEC    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_MADDR  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_MRD    = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_MWB    = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_MWR    = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_REX    = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [16:0] SB_RWB    = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_IEX    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_IWB    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [16:0] SB_BR     = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [16:0] SB_JMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [16:0] SB_TRAP   = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t q1[$];
  exp_t q2[$];

  multicycle_control_if #(.COUNT_W(32)) bus1 ();
  multicycle_control_if #(.COUNT_W(3))  bus2 ();

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .COUNT_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b0), .COUNT_W(3)) u_dut_nh (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  logic [16:0] sb1;
  logic [16:0] sb2;
  assign sb1 = {bus1.pc_write, bus1.pc_write_cond, bus1.i_or_d, bus1.mem_read, bus1.mem_write,
                bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst, bus1.reg_write, bus1.alu_src_a,
                bus1.alu_src_b, bus1.alu_op, bus1.pc_source, bus1.illegal_instr};
  assign sb2 = {bus2.pc_write, bus2.pc_write_cond, bus2.i_or_d, bus2.mem_read, bus2.mem_write,
                bus2.ir_write, bus2.mem_to_reg, bus2.reg_dst, bus2.reg_write, bus2.alu_src_a,
                bus2.alu_src_b, bus2.alu_op, bus2.pc_source, bus2.illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor for the handshake instance
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      check("dut_state", 32'(bus1.state), 32'(e.st));
      check("dut_strobes", 32'(sb1), 32'(e.sb));
      check("dut_count", bus1.instr_count, e.cnt);
    end
  end

  // Monitor for the no-handshake instance
  always @(negedge clk) begin
    if (q2.size() > 0) begin
      exp_t e;
      e = q2.pop_front();
      check("nh_state", 32'(bus2.state), 32'(e.st));
      check("nh_strobes", 32'(sb2), 32'(e.sb));
      check("nh_count", 32'(bus2.instr_count), e.cnt);
    end
  end

  // One cycle of stimulus with its expected response
  task automatic step(input logic [3:0] st, input logic [16:0] sb, input logic [31:0] cnt,
                      input logic rdy);
    bus1.mem_ready = rdy;
    q1.push_back('{st: st, sb: sb, cnt: cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus1.opcode    = OP_R;
    bus1.zero      = 1'b0;
    bus1.mem_ready = 1'b0;
    bus2.opcode    = OP_SW;
    bus2.zero      = 1'b0;
    bus2.mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus1.state), 32'(S_IDLE));
    check("rst_strobes", 32'(sb1), 32'(SB_IDLE));
    check("rst_count", bus1.instr_count, 32'd0);

    // Release; sw loop on the no-handshake instance: 4 cycles each, 3-bit counter wraps at 8
    rst_n = 1'b1;
    q2.push_back('{st: S_IDLE, sb: SB_IDLE, cnt: 32'd0});
    for (int k = 1; k < 34; k++) begin
      logic [3:0]  st;
      logic [16:0] sb;
      case ((k - 1) % 4)
        0:       begin st = S_FETCH; sb = SB_FGO;   end
        1:       begin st = S_DEC;   sb = SB_DEC;   end
        2:       begin st = S_MADDR; sb = SB_MADDR; end
        default: begin st = S_MWR;   sb = SB_MWR;   end
      endcase
      q2.push_back('{st: st, sb: sb, cnt: 32'(((k - 1) / 4) % 8)});
    end

    step(S_IDLE, SB_IDLE, 0, 1'b1);

    // R-type
    bus1.opcode = OP_R;
    step(S_FETCH, SB_FGO, 0, 1'b1);
    step(S_DEC,   SB_DEC, 0, 1'b1);
    step(S_REX,   SB_REX, 0, 1'b1);
    step(S_RWB,   SB_RWB, 0, 1'b1);

    // lw with two wait cycles in MEM_RD; mem_ready low outside memory states is ignored
    bus1.opcode = OP_LW;
    step(S_FETCH, SB_FGO,   1, 1'b1);
    step(S_DEC,   SB_DEC,   1, 1'b0);
    step(S_MADDR, SB_MADDR, 1, 1'b0);
    step(S_MRD,   SB_MRD,   1, 1'b0);
    step(S_MRD,   SB_MRD,   1, 1'b0);
    step(S_MRD,   SB_MRD,   1, 1'b1);
    step(S_MWB,   SB_MWB,   1, 1'b0);

    // beq taken then not taken; outputs identical
    bus1.opcode = OP_BEQ;
    bus1.zero   = 1'b1;
    step(S_FETCH, SB_FGO, 2, 1'b1);
    step(S_DEC,   SB_DEC, 2, 1'b1);
    step(S_BR,    SB_BR,  2, 1'b1);
    bus1.zero   = 1'b0;
    step(S_FETCH, SB_FGO, 3, 1'b1);
    step(S_DEC,   SB_DEC, 3, 1'b1);
    step(S_BR,    SB_BR,  3, 1'b1);

    // Illegal opcode, with one FETCH wait cycle first
    bus1.opcode = OP_BAD;
    step(S_FETCH, SB_FSTALL, 4, 1'b0);
    step(S_FETCH, SB_FGO,    4, 1'b1);
    step(S_DEC,   SB_DEC,    4, 1'b1);
    step(S_TRAP,  SB_TRAP,   4, 1'b1);

    // j
    bus1.opcode = OP_J;
    step(S_FETCH, SB_FGO, 5, 1'b1);
    step(S_DEC,   SB_DEC, 5, 1'b1);
    step(S_JMP,   SB_JMP, 5, 1'b1);

    // addi, addiu
    bus1.opcode = OP_ADDI;
    step(S_FETCH, SB_FGO, 6, 1'b1);
    step(S_DEC,   SB_DEC, 6, 1'b1);
    step(S_IEX,   SB_IEX, 6, 1'b1);
    step(S_IWB,   SB_IWB, 6, 1'b1);
    bus1.opcode = OP_ADDIU;
    step(S_FETCH, SB_FGO, 7, 1'b1);
    step(S_DEC,   SB_DEC, 7, 1'b1);
    step(S_IEX,   SB_IEX, 7, 1'b1);
    step(S_IWB,   SB_IWB, 7, 1'b1);

    // sw, aborted by reset while stalled in MEM_WR
    bus1.opcode = OP_SW;
    step(S_FETCH, SB_FGO,   8, 1'b1);
    step(S_DEC,   SB_DEC,   8, 1'b0);
    step(S_MADDR, SB_MADDR, 8, 1'b0);
    bus1.mem_ready = 1'b0;
    #1;
    check("mwr_state", 32'(bus1.state), 32'(S_MWR));
    check("mwr_mem_write", 32'(bus1.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(bus1.state), 32'(S_IDLE));
    check("async_strobes", 32'(sb1), 32'(SB_IDLE));
    check("async_count", bus1.instr_count, 32'd0);
    check("async_nh_count", 32'(bus2.instr_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held_state", 32'(bus1.state), 32'(S_IDLE));
    rst_n = 1'b1;

    // Restart: IDLE, then FETCH with a cleared counter
    bus1.opcode = OP_R;
    step(S_IDLE,  SB_IDLE, 0, 1'b1);
    step(S_FETCH, SB_FGO,  0, 1'b1);
    step(S_DEC,   SB_DEC,  0, 1'b1);
    step(S_REX,   SB_REX,  0, 1'b1);
    step(S_RWB,   SB_RWB,  0, 1'b1);
    step(S_FETCH, SB_FGO,  1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
